// File: rtl/alu_cmd_sequencer_if.sv
// Requester, ALU-drive and response signals of alu_cmd_sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_cmd_sequencer_if #(
    parameter int PTR_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [15:0]      cmd_a;
    logic [15:0]      cmd_b;
    logic [3:0]       cmd_op;
    logic [15:0]      alu_a_in;
    logic [15:0]      alu_b_in;
    logic [3:0]       alu_opcode;
    logic [15:0]      alu_result;
    logic             alu_error;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [15:0]      rsp_result;
    logic             rsp_error;
    logic [3:0]       rsp_op;
    logic [PTR_W:0]   fifo_count;
    logic [15:0]      ops_done;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_error, rsp_ready,
        output cmd_ready, alu_a_in, alu_b_in, alu_opcode,
               rsp_valid, rsp_result, rsp_error, rsp_op, fifo_count, ops_done
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, alu_result, alu_error, rsp_ready,
        input  cmd_ready, alu_a_in, alu_b_in, alu_opcode,
               rsp_valid, rsp_result, rsp_error, rsp_op, fifo_count, ops_done
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to the ALU and returns each
// captured result over a valid/ready response port.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               clk,
    input  logic               reset,
    alu_cmd_sequencer_if.slave bus
);
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    state_t           r_state;
    cmd_t             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;
    logic [15:0]      r_alu_a;
    logic [15:0]      r_alu_b;
    logic [3:0]       r_alu_op;
    logic [3:0]       r_cur_op;
    logic             r_rsp_valid;
    logic [15:0]      r_rsp_result;
    logic             r_rsp_error;
    logic [3:0]       r_rsp_op;
    logic [15:0]      r_ops_done;

    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    cmd_t             w_head;

    // Ready is gated by reset so it reads 0 for the whole time reset is held.
    assign w_empty       = (r_count == '0);
    assign bus.cmd_ready = reset && (r_count != FULL);
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign w_pop         = !w_empty && ((r_state == IDLE) || ((r_state == RESP) && bus.rsp_ready));
    assign w_head        = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The ALU registers its inputs at the edge closing ISSUE, so alu_* carry
    // the command for that one cycle only and are NOP everywhere else.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_cur_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_error  <= 1'b0;
            r_rsp_op     <= '0;
            r_ops_done   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_state                       <= ISSUE;
                        {r_alu_a, r_alu_b, r_alu_op}  <= w_head;
                        r_cur_op                      <= w_head.op;
                    end
                end
                ISSUE: begin
                    r_state  <= WAIT;
                    r_alu_a  <= '0;
                    r_alu_b  <= '0;
                    r_alu_op <= '0;
                end
                WAIT: begin
                    r_state      <= RESP;
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= bus.alu_result;
                    r_rsp_error  <= bus.alu_error;
                    r_rsp_op     <= r_cur_op;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ops_done  <= r_ops_done + 16'd1;
                        if (!w_empty) begin
                            r_state                      <= ISSUE;
                            {r_alu_a, r_alu_b, r_alu_op} <= w_head;
                            r_cur_op                     <= w_head.op;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.alu_a_in   = r_alu_a;
    assign bus.alu_b_in   = r_alu_b;
    assign bus.alu_opcode = r_alu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_rsp_result;
    assign bus.rsp_error  = r_rsp_error;
    assign bus.rsp_op     = r_rsp_op;
    assign bus.fifo_count = r_count;
    assign bus.ops_done   = r_ops_done;
endmodule
